i2c_eeprom_responder: RTL

- I2C target emulating a 24Cxx-style EEPROM: device address 1010_bbb, 8-bit word address, sequential read/write.
- Holds a small config byte array (id, baudrate) and exposes it to the local design.
- Sits on a board's I2C pins and lets a host or another motor board program the same config bytes the EEPROM reader fetches, and read them back.

---
 rtl/i2c_eeprom_responder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/i2c_eeprom_responder.sv
// I2C target emulating a small 24Cxx-style EEPROM (device 1010_bbb, 8-bit word address).
// The first five bytes are exported as the id and baudrate configuration.
module i2c_eeprom_responder #(
    parameter logic [2:0] BLOCK  = 3'b000,
    parameter int         ADDR_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_out,
    output logic        sda_enable,
    output logic [7:0]  id,
    output logic [31:0] baudrate,
    output logic        busy,
    output logic        write_done
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE, DEV_ADDR, ACK, WORD_ADDR, WRITE_DATA, READ_DATA, READ_ACK
    } state_t;

    state_t              state_q, nxt_q;
    logic [2:0]          scl_q, sda_q;
    logic [2:0]          bit_cnt_q;
    logic [7:0]          shift_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [7:0]          mem_q [DEPTH];
    logic                phase_q, rd_ack_q, sda_en_q, busy_q, wrote_q, wd_q;

    // [1] is the synchronised level, [2] the previous synchronised level
    logic scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
    logic [7:0] byte_w;
    assign scl_s    = scl_q[1];
    assign sda_s    = sda_q[1];
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start_c  = scl_s & ~sda_q[1] & sda_q[2];
    assign stop_c   = scl_s & sda_q[1] & ~sda_q[2];
    assign byte_w   = {shift_q[6:0], sda_s};

    assign sda_out    = 1'b0;
    assign sda_enable = sda_en_q;
    assign busy       = busy_q;
    assign write_done = wd_q;
    assign id         = mem_q[0];
    assign baudrate   = {mem_q[ADDR_W'(4)], mem_q[ADDR_W'(3)], mem_q[ADDR_W'(2)], mem_q[ADDR_W'(1)]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            nxt_q     <= IDLE;
            scl_q     <= 3'b111;
            sda_q     <= 3'b111;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            phase_q   <= 1'b0;
            rd_ack_q  <= 1'b0;
            sda_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            wrote_q   <= 1'b0;
            wd_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            scl_q <= {scl_q[1:0], scl_in};
            sda_q <= {sda_q[1:0], sda_in};
            wd_q  <= 1'b0;
            if (start_c) begin
                state_q   <= DEV_ADDR;
                bit_cnt_q <= '0;
                sda_en_q  <= 1'b0;
                busy_q    <= 1'b0;
                wrote_q   <= 1'b0;
            end else if (stop_c) begin
                state_q  <= IDLE;
                sda_en_q <= 1'b0;
                busy_q   <= 1'b0;
                wd_q     <= wrote_q;
                wrote_q  <= 1'b0;
            end else begin
                case (state_q)
                    DEV_ADDR: if (scl_rise) begin
                        shift_q   <= byte_w;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_w[7:1] == {4'b1010, BLOCK}) begin
                                state_q <= ACK;
                                nxt_q   <= byte_w[0] ? READ_DATA : WORD_ADDR;
                                phase_q <= 1'b0;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    // phase 0: pull low for the ACK bit; phase 1: release or start read data
                    ACK: if (scl_fall) begin
                        if (!phase_q) begin
                            sda_en_q <= 1'b1;
                            phase_q  <= 1'b1;
                        end else begin
                            phase_q   <= 1'b0;
                            state_q   <= nxt_q;
                            bit_cnt_q <= '0;
                            sda_en_q  <= 1'b0;
                            if (nxt_q == READ_DATA) begin
                                shift_q   <= mem_q[ptr_q];
                                sda_en_q  <= ~mem_q[ptr_q][7];
                                bit_cnt_q <= 3'd1;
                            end
                        end
                    end
                    WORD_ADDR: if (scl_rise) begin
                        shift_q   <= byte_w;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_q   <= byte_w[ADDR_W-1:0];
                            state_q <= ACK;
                            nxt_q   <= WRITE_DATA;
                            phase_q <= 1'b0;
                        end
                    end
                    WRITE_DATA: if (scl_rise) begin
                        shift_q   <= byte_w;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            mem_q[ptr_q] <= byte_w;
                            ptr_q        <= ptr_q + ADDR_W'(1);
                            wrote_q      <= 1'b1;
                            state_q      <= ACK;
                            nxt_q        <= WRITE_DATA;
                            phase_q      <= 1'b0;
                        end
                    end
                    // bit_cnt counts bits already driven; wrap to 0 means all 8 are out
                    READ_DATA: if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_en_q <= 1'b0;
                            rd_ack_q <= 1'b0;
                            state_q  <= READ_ACK;
                        end else begin
                            sda_en_q  <= ~shift_q[3'd7 - bit_cnt_q];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                ptr_q    <= ptr_q + ADDR_W'(1);
                                rd_ack_q <= 1'b1;
                            end
                        end else if (scl_fall && rd_ack_q) begin
                            rd_ack_q  <= 1'b0;
                            shift_q   <= mem_q[ptr_q];
                            sda_en_q  <= ~mem_q[ptr_q][7];
                            bit_cnt_q <= 3'd1;
                            state_q   <= READ_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
